sa1_ss_restore: RTL

//  Savestate-load counterpart of the SA-1 register shadow: replays saved SA-1 control bytes back into the chip.
//  On start, fetches each byte from the savestate image window ($C0:2200-$23FF offsets) via a req/ack port.

---
 rtl/sa1_ss_pkg.sv | 46 ++++
 rtl/sa1_ss_restore_table.sv | 16 +
 rtl/sa1_ss_restore.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sa1_ss_pkg.sv
// -----------------------------------------------------------------------------
// sa1_ss_pkg
// Shared definitions for the SA-1 savestate restore sequencer.
//   sa1_ss_state_t  : sequencer FSM states
//   sa1_ss_entry_t  : restore table entry {addr, side, verify_mask}
//   restore_entry() : constant 6-entry restore table (idx -> entry)
//   SA1_REG_BASE    : base address of the SA-1 register window ($2200)
// Optional feature macro used by the sequencer: SA1_RESTORE_VERIFY_EN
// -----------------------------------------------------------------------------
package sa1_ss_pkg;

    localparam logic [15:0] SA1_REG_BASE = 16'h2200;
    localparam int          NUM_ENTRIES  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_GAP,
        ST_VERIFY,
        ST_DONE
    } sa1_ss_state_t;

    typedef struct packed {
        logic [7:0] addr;         // low byte of $22xx
        logic       side;         // 0 = SNES-side port, 1 = SA-1-side port
        logic [7:0] verify_mask;  // readback bits compared; 0 = write-only
    } sa1_ss_entry_t;

    // $2200 is last so the SA-1 only leaves reset once vectors and NMI
    // enable are already in place.
    function automatic sa1_ss_entry_t restore_entry(input logic [2:0] idx);
        sa1_ss_entry_t e;
        case (idx)
            3'd0:    e = '{addr: 8'h03, side: 1'b0, verify_mask: 8'h00};
            3'd1:    e = '{addr: 8'h04, side: 1'b0, verify_mask: 8'h00};
            3'd2:    e = '{addr: 8'h05, side: 1'b0, verify_mask: 8'h00};
            3'd3:    e = '{addr: 8'h06, side: 1'b0, verify_mask: 8'h00};
            3'd4:    e = '{addr: 8'h0A, side: 1'b1, verify_mask: 8'h10};
            3'd5:    e = '{addr: 8'h00, side: 1'b0, verify_mask: 8'h20};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sa1_ss_restore_table.sv
// -----------------------------------------------------------------------------
// sa1_ss_restore_table
// Combinational ROM: restore sequence index -> table entry.
//   i_idx   : entry index (0..5)
//   o_entry : {addr, side, verify_mask} for that index
// -----------------------------------------------------------------------------
import sa1_ss_pkg::*;

module sa1_ss_restore_table (
    input  logic [2:0]    i_idx,
    output sa1_ss_entry_t o_entry
);

    assign o_entry = restore_entry(i_idx);

endmodule

// File: rtl/sa1_ss_restore.sv
// -----------------------------------------------------------------------------
// sa1_ss_restore
// Savestate-load sequencer: fetches the saved SA-1 control bytes from the
// savestate image ($2200-$23FF window) and replays them into the live SA-1
// register file as injected bus writes, $2200 last.
//
// Optional feature: define SA1_RESTORE_VERIFY_EN to add a readback VERIFY
// step after masked entries ($0A bit4, $00 bit5) with a sticky mismatch flag.
// Without it reg_rd/mismatch are tied 0 and reg_di is ignored.
//
// Ports
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_active            : cart is SA-1; low aborts and holds everything idle
//   i_start             : pulse, begin restore sequence
//   o_busy, o_done      : sequence in progress / one-cycle end pulse
//   o_error             : sticky fetch timeout, cleared on accepted start
//   o_ss_rd_req/addr    : savestate byte request, held until i_ss_rd_ack
//   i_ss_rd_ack/data    : savestate byte return
//   o_reg_wr            : register write strobe, WR_CYCLES clocks
//   o_reg_side/addr/do  : write target port, $22xx low byte, write data
//   o_mismatch, o_reg_rd: verify result / readback strobe
//   i_reg_di            : readback data
// -----------------------------------------------------------------------------
import sa1_ss_pkg::*;

module sa1_ss_restore #(
    parameter int WR_CYCLES     = 4,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_active,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic       o_ss_rd_req,
    output logic [8:0] o_ss_rd_addr,
    input  logic       i_ss_rd_ack,
    input  logic [7:0] i_ss_rd_data,
    output logic       o_reg_wr,
    output logic       o_reg_side,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_do,
    output logic       o_mismatch,
    output logic       o_reg_rd,
    input  logic [7:0] i_reg_di
);

    localparam logic [7:0] WR_LAST  = 8'(WR_CYCLES - 1);
    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_ENTRIES - 1);

    sa1_ss_state_t r_state, w_state_nxt;
    logic [2:0]    r_idx;
    logic [7:0]    r_cnt;
    logic [7:0]    r_reg_do;
    logic          r_error;

    logic          w_accept, w_latch, w_err_set, w_idx_inc;
    logic          w_cnt_clr, w_cnt_inc;
    sa1_ss_entry_t w_entry;

    sa1_ss_restore_table u_table (
        .i_idx   (r_idx),
        .o_entry (w_entry)
    );

`ifdef SA1_RESTORE_VERIFY_EN
    logic r_mismatch;
    logic w_mm_set;
`endif

    // ---- state register ----------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_active) r_state <= ST_IDLE;
        else                      r_state <= w_state_nxt;
    end

    // ---- next state / control ----------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_latch     = 1'b0;
        w_err_set   = 1'b0;
        w_idx_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
`ifdef SA1_RESTORE_VERIFY_EN
        w_mm_set    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // ack wins over timeout if both land on the last cycle
                if (i_ss_rd_ack) begin
                    w_latch     = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_WRITE;
                end else if (r_cnt == TMO_LAST) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            ST_WRITE: begin
                if (r_cnt == WR_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            ST_GAP: begin
                w_cnt_clr = 1'b1;
`ifdef SA1_RESTORE_VERIFY_EN
                if (w_entry.verify_mask != 8'h00) w_state_nxt = ST_VERIFY;
                else
`endif
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_inc   = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
`ifdef SA1_RESTORE_VERIFY_EN
            ST_VERIFY: begin
                // readback is only trusted on the second strobe cycle
                if (r_cnt == 8'd1) begin
                    w_mm_set  = |((i_reg_di ^ r_reg_do) & w_entry.verify_mask);
                    w_cnt_clr = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_inc   = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
`endif
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ---- datapath registers ------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_active) begin
            r_idx    <= '0;
            r_cnt    <= '0;
            r_reg_do <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_accept)       r_idx <= '0;
            else if (w_idx_inc) r_idx <= r_idx + 3'd1;

            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;

            if (w_latch)        r_reg_do <= i_ss_rd_data;

            if (w_accept)       r_error <= 1'b0;
            else if (w_err_set) r_error <= 1'b1;
        end
    end

`ifdef SA1_RESTORE_VERIFY_EN
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_active) r_mismatch <= 1'b0;
        else if (w_accept)        r_mismatch <= 1'b0;
        else if (w_mm_set)        r_mismatch <= 1'b1;
    end

    assign o_mismatch = r_mismatch;
    assign o_reg_rd   = (r_state == ST_VERIFY);
`else
    logic w_unused_verify;
    assign w_unused_verify = ^{i_reg_di, w_entry.verify_mask};
    assign o_mismatch      = 1'b0;
    assign o_reg_rd        = 1'b0;
`endif

    // ---- outputs -----------------------------------------------------------
    assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done       = (r_state == ST_DONE);
    assign o_error      = r_error;
    assign o_ss_rd_req  = (r_state == ST_FETCH);
    assign o_reg_wr     = (r_state == ST_WRITE);
    assign o_reg_addr   = o_busy ? w_entry.addr : 8'h00;
    assign o_reg_side   = o_busy & w_entry.side;
    assign o_ss_rd_addr = {1'b0, o_reg_addr};

    // During FETCH the returning byte is passed straight through so the write
    // data is already valid on the ack cycle, one clock ahead of reg_wr.
    assign o_reg_do = (r_state == ST_FETCH) ? i_ss_rd_data :
                      (o_busy ? r_reg_do : 8'h00);

endmodule
